// File: rtl/timestamp_fifo_reader.sv
// Pops 32-bit timestamp words from a FWFT FIFO, checks identifier and index order,
// and presents each reassembled 64-bit timestamp on a valid/ready handshake.
module timestamp_fifo_reader #(
  parameter logic [6:0] IDENTIFIER   = 7'b0000001,
  parameter int         ERRCNT_WIDTH = 8
) (
  input  logic                    BUS_CLK,
  input  logic                    BUS_RST,
  input  logic                    FIFO_EMPTY,
  input  logic [31:0]             FIFO_DATA,
  output logic                    FIFO_READ,
  output logic                    TS_VALID,
  input  logic                    TS_READY,
  output logic [63:0]             TS_DATA,
  output logic [ERRCNT_WIDTH-1:0] ERR_ID_CNT,
  output logic [ERRCNT_WIDTH-1:0] ERR_SEQ_CNT,
  input  logic                    CLR_ERR
);

  typedef enum logic [1:0] {
    W0  = 2'd0,
    W1  = 2'd1,
    W2  = 2'd2,
    OUT = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic [45:0]             asm_r;
  logic [63:0]             ts_data_r;
  logic                    ts_valid_r;
  logic [ERRCNT_WIDTH-1:0] err_id_r;
  logic [ERRCNT_WIDTH-1:0] err_seq_r;

  logic       accept_s;
  logic       id_ok_s;
  logic [1:0] idx_s;
  logic       load0_s;
  logic       load1_s;
  logic       ts_load_s;
  logic       id_err_s;
  logic       seq_err_s;

  function automatic logic [ERRCNT_WIDTH-1:0] sat_inc(input logic [ERRCNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(ERRCNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Reads are blocked while a finished timestamp waits and while reset is held.
  assign FIFO_READ = (state_r != OUT) & ~FIFO_EMPTY & ~BUS_RST;
  assign accept_s  = FIFO_READ;
  assign id_ok_s   = (FIFO_DATA[31:25] == IDENTIFIER);
  assign idx_s     = FIFO_DATA[24:23];

  assign TS_VALID    = ts_valid_r;
  assign TS_DATA     = ts_data_r;
  assign ERR_ID_CNT  = err_id_r;
  assign ERR_SEQ_CNT = err_seq_r;

  // Next-state and word classification
  always_comb begin
    state_next_s = state_r;
    load0_s      = 1'b0;
    load1_s      = 1'b0;
    ts_load_s    = 1'b0;
    id_err_s     = 1'b0;
    seq_err_s    = 1'b0;
    case (state_r)
      W0, W1, W2: begin
        if (!accept_s) begin
          state_next_s = state_r;
        end else if (!id_ok_s) begin
          id_err_s = 1'b1;
        end else if (state_r == W0 && idx_s == 2'd0) begin
          load0_s      = 1'b1;
          state_next_s = W1;
        end else if (state_r == W1 && idx_s == 2'd1) begin
          load1_s      = 1'b1;
          state_next_s = W2;
        end else if (state_r == W2 && idx_s == 2'd2) begin
          ts_load_s    = 1'b1;
          state_next_s = OUT;
        end else if (idx_s == 2'd0) begin
          seq_err_s    = 1'b1;
          load0_s      = 1'b1;
          state_next_s = W1;
        end else begin
          seq_err_s    = 1'b1;
          state_next_s = W0;
        end
      end
      OUT: begin
        if (TS_READY) begin
          state_next_s = W0;
        end else begin
          state_next_s = OUT;
        end
      end
      default: state_next_s = W0;
    endcase
  end

  // State, assembly, output and saturating error counters
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state_r    <= W0;
      asm_r      <= 46'd0;
      ts_data_r  <= 64'd0;
      ts_valid_r <= 1'b0;
      err_id_r   <= {ERRCNT_WIDTH{1'b0}};
      err_seq_r  <= {ERRCNT_WIDTH{1'b0}};
    end else begin
      state_r    <= state_next_s;
      ts_valid_r <= (state_next_s == OUT);
      if (load0_s) begin
        asm_r[22:0] <= FIFO_DATA[22:0];
      end else if (load1_s) begin
        asm_r[45:23] <= FIFO_DATA[22:0];
      end
      if (ts_load_s) begin
        ts_data_r <= {FIFO_DATA[17:0], asm_r};
      end
      if (CLR_ERR) begin
        err_id_r  <= {ERRCNT_WIDTH{1'b0}};
        err_seq_r <= {ERRCNT_WIDTH{1'b0}};
      end else begin
        if (id_err_s) begin
          err_id_r <= sat_inc(err_id_r);
        end
        if (seq_err_s) begin
          err_seq_r <= sat_inc(err_seq_r);
        end
      end
    end
  end

endmodule

// File: tb/tb_timestamp_fifo_reader.sv
// Directed bench: FIFO source model plus a timestamp scoreboard checked at each handshake.
module tb_timestamp_fifo_reader;
  logic        BUS_CLK;
  logic        BUS_RST;
  logic        FIFO_EMPTY;
  logic [31:0] FIFO_DATA;
  logic        FIFO_READ;
  logic        TS_VALID;
  logic        TS_READY;
  logic [63:0] TS_DATA;
  logic [7:0]  ERR_ID_CNT;
  logic [7:0]  ERR_SEQ_CNT;
  logic        CLR_ERR;

  timestamp_fifo_reader #(.IDENTIFIER(7'b0000001), .ERRCNT_WIDTH(8)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA),
    .FIFO_READ(FIFO_READ), .TS_VALID(TS_VALID), .TS_READY(TS_READY), .TS_DATA(TS_DATA),
    .ERR_ID_CNT(ERR_ID_CNT), .ERR_SEQ_CNT(ERR_SEQ_CNT), .CLR_ERR(CLR_ERR)
  );

  initial begin
    BUS_CLK = 1'b0;
    forever #5 BUS_CLK = ~BUS_CLK;
  end

  logic [31:0] src_q[$];
  logic [63:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_rise = -1;
  int rises = 0;
  logic chk_stream = 1'b0;
  logic pre_read, pre_valid, pre_ready, pre_empty;
  logic [63:0] pre_data;

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkw(input logic [6:0] id, input logic [1:0] idx, input logic [22:0] pl);
    return {id, idx, pl};
  endfunction

  task automatic push_ts(input logic [63:0] ts);
    src_q.push_back(mkw(7'd1, 2'd0, ts[22:0]));
    src_q.push_back(mkw(7'd1, 2'd1, ts[45:23]));
    src_q.push_back(mkw(7'd1, 2'd2, {5'd0, ts[63:46]}));
    exp_q.push_back(ts);
  endtask

  // One clock: drive FIFO head, sample before the edge, pop/score after it.
  task automatic tick();
    logic [63:0] e;
    FIFO_EMPTY = (src_q.size() == 0);
    FIFO_DATA  = FIFO_EMPTY ? 32'h0 : src_q[0];
    #1;
    pre_read = FIFO_READ; pre_valid = TS_VALID; pre_ready = TS_READY;
    pre_data = TS_DATA;   pre_empty = FIFO_EMPTY;
    if (chk_stream && !pre_empty) check64("read_only_outside_out", {63'd0, pre_read}, {63'd0, ~pre_valid});
    @(posedge BUS_CLK);
    cyc++;
    if (pre_read && !pre_empty) void'(src_q.pop_front());
    if (pre_valid && pre_ready) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL ts_spurious observed=%h expected=none", pre_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check64("ts_data", pre_data, e);
      end
    end
    #1;
    if (TS_VALID && !pre_valid) begin
      if (chk_stream && last_rise >= 0) check64("valid_spacing", 64'(cyc - last_rise), 64'd4);
      last_rise = cyc;
      rises++;
    end
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while ((src_q.size() != 0 || TS_VALID) && n < budget);
    check64("idle_within_budget", {63'd0, (src_q.size() == 0 && !TS_VALID)}, 64'd1);
    check64("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic clr();
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
  endtask

  initial begin
    logic [63:0] ts_a, ts_b;
    BUS_RST = 1'b1; FIFO_EMPTY = 1'b1; FIFO_DATA = 32'h0; TS_READY = 1'b1; CLR_ERR = 1'b0;
    #2;
    check64("rst_valid", {63'd0, TS_VALID}, 64'd0);
    check64("rst_read", {63'd0, FIFO_READ}, 64'd0);
    check64("rst_data", TS_DATA, 64'd0);
    check64("rst_errid", {56'd0, ERR_ID_CNT}, 64'd0);
    check64("rst_errseq", {56'd0, ERR_SEQ_CNT}, 64'd0);
    BUS_RST = 1'b0;
    @(posedge BUS_CLK); #1;

    // Basic triplet
    src_q.push_back(mkw(7'd1, 2'd0, 23'h000ABC));
    src_q.push_back(mkw(7'd1, 2'd1, 23'h000001));
    src_q.push_back(mkw(7'd1, 2'd2, 23'h03FFFF));
    exp_q.push_back(64'hFFFF_C000_0080_0ABC);
    rises = 0;
    run_idle(20);
    check64("t1_pulses", 64'(rises), 64'd1);
    check64("t1_errid", {56'd0, ERR_ID_CNT}, 64'd0);
    check64("t1_errseq", {56'd0, ERR_SEQ_CNT}, 64'd0);

    // Back-to-back stream, one timestamp every 4 cycles
    for (int i = 0; i < 4; i++) push_ts({$urandom, $urandom});
    rises = 0; last_rise = -1; chk_stream = 1'b1;
    run_idle(40);
    chk_stream = 1'b0;
    check64("t2_pulses", 64'(rises), 64'd4);

    // Downstream stall
    TS_READY = 1'b0;
    ts_a = 64'h1234_5678_9ABC_DEF0;
    ts_b = 64'h0FED_CBA9_8765_4321;
    push_ts(ts_a);
    push_ts(ts_b);
    for (int n = 0; n < 20 && !TS_VALID; n++) tick();
    check64("t3_valid_rise", {63'd0, TS_VALID}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check64("t3_stall_read", {63'd0, pre_read}, 64'd0);
      check64("t3_stall_valid", {63'd0, pre_valid}, 64'd1);
      check64("t3_stall_data", pre_data, ts_a);
    end
    TS_READY = 1'b1;
    tick();
    check64("t3_hs_read", {63'd0, pre_read}, 64'd0);
    tick();
    check64("t3_read_after_hs", {63'd0, pre_read}, 64'd1);
    run_idle(20);

    // Identifier mismatch between index 0 and index 1
    clr();
    ts_a = 64'h0003_1415_9265_3589;
    src_q.push_back(mkw(7'd1, 2'd0, ts_a[22:0]));
    src_q.push_back(mkw(7'd2, 2'd1, 23'h7FFFFF));
    src_q.push_back(mkw(7'd1, 2'd1, ts_a[45:23]));
    src_q.push_back(mkw(7'd1, 2'd2, {5'd0, ts_a[63:46]}));
    exp_q.push_back(ts_a);
    run_idle(20);
    check64("t4_errid", {56'd0, ERR_ID_CNT}, 64'd1);
    check64("t4_errseq", {56'd0, ERR_SEQ_CNT}, 64'd0);

    // Repeated index 0 restarts assembly
    clr();
    ts_b = 64'hA5A5_5A5A_C3C3_3C3C;
    src_q.push_back(mkw(7'd1, 2'd0, 23'h111111));
    src_q.push_back(mkw(7'd1, 2'd0, ts_b[22:0]));
    src_q.push_back(mkw(7'd1, 2'd1, ts_b[45:23]));
    src_q.push_back(mkw(7'd1, 2'd2, {5'd0, ts_b[63:46]}));
    exp_q.push_back(ts_b);
    rises = 0;
    run_idle(20);
    check64("t5_pulses", 64'(rises), 64'd1);
    check64("t5_errseq", {56'd0, ERR_SEQ_CNT}, 64'd1);

    // Index 0 then index 2: dropped, no output
    clr();
    rises = 0;
    src_q.push_back(mkw(7'd1, 2'd0, 23'h0000AA));
    src_q.push_back(mkw(7'd1, 2'd2, 23'h0000BB));
    run_idle(20);
    tick();
    check64("t6_pulses", 64'(rises), 64'd0);
    check64("t6_errseq", {56'd0, ERR_SEQ_CNT}, 64'd1);
    check64("t6_errid", {56'd0, ERR_ID_CNT}, 64'd0);

    // Reset mid-assembly discards partial data and counters
    src_q.push_back(mkw(7'd1, 2'd0, 23'h123456));
    src_q.push_back(mkw(7'd3, 2'd0, 23'h000000));
    src_q.push_back(mkw(7'd1, 2'd1, 23'h654321));
    for (int i = 0; i < 3; i++) tick();
    check64("t7_pre_errid", {56'd0, ERR_ID_CNT}, 64'd1);
    ts_a = 64'h0000_0000_DEAD_BEEF;
    push_ts(ts_a);
    BUS_RST = 1'b1;
    FIFO_EMPTY = 1'b0;
    FIFO_DATA = src_q[0];
    #1;
    check64("t7_rst_read", {63'd0, FIFO_READ}, 64'd0);
    check64("t7_rst_errid", {56'd0, ERR_ID_CNT}, 64'd0);
    check64("t7_rst_errseq", {56'd0, ERR_SEQ_CNT}, 64'd0);
    BUS_RST = 1'b0;
    rises = 0;
    run_idle(20);
    check64("t7_pulses", 64'(rises), 64'd1);
    check64("t7_errid", {56'd0, ERR_ID_CNT}, 64'd0);
    check64("t7_errseq", {56'd0, ERR_SEQ_CNT}, 64'd0);

    // Saturation, then clear with a coincident bad word
    for (int i = 0; i < 300; i++) src_q.push_back(mkw(7'd5, 2'(i), 23'(i)));
    run_idle(400);
    check64("t8_errid_sat", {56'd0, ERR_ID_CNT}, 64'd255);
    src_q.push_back(mkw(7'd5, 2'd0, 23'd0));
    clr();
    check64("t8_clear_read", {63'd0, pre_read}, 64'd1);
    check64("t8_errid_clr", {56'd0, ERR_ID_CNT}, 64'd0);
    check64("t8_errseq", {56'd0, ERR_SEQ_CNT}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
